// File: rtl/status_pkg.sv
// Shared types and constants for the status display controller.
package status_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = 4'd15;

endpackage

// File: rtl/status_timer.sv
// Loadable down-counter; expire_o pulses for one cycle as the count passes 1 -> 0.
module status_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // A load wins over a clear so a restart in the exit cycle still reloads.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (clr_i) begin
            count_d = '0;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/status_ctrl.sv
// Check-result status controller: timed result display, failure streak and lockout.
// Define STATUS_BLINK_EN to blink "done" while an incorrect result is shown.
module status_ctrl
    import status_pkg::*;
#(
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int MAX_FAILS    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                check_valid,
    input  logic                check_ok,
    input  logic                ack,
    output logic                done,
    output logic                incorrect,
    output logic                locked,
    output logic [STREAK_W-1:0] fail_streak
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1 || BLINK_CYCLES < 1 || MAX_FAILS < 1 || MAX_FAILS > 15) begin : gParamCheck
        $error("status_ctrl: parameter out of range");
    end

    state_t              state_q, state_d;
    logic                done_q, done_d;
    logic                incorrect_q, incorrect_d;
    logic                locked_q;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [STREAK_W-1:0] streakInc;
    logic                holdLoad, holdClr, holdExpire;

    status_timer #(.WIDTH(HOLD_W)) uHoldTimer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (holdLoad),
        .clr_i      (holdClr),
        .load_val_i (HOLD_W'(HOLD_CYCLES)),
        .expire_o   (holdExpire)
    );

`ifdef STATUS_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    logic blinkLoad, blinkClr, blinkExpire;

    status_timer #(.WIDTH(BLINK_W)) uBlinkTimer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (blinkLoad),
        .clr_i      (blinkClr),
        .load_val_i (BLINK_W'(BLINK_CYCLES)),
        .expire_o   (blinkExpire)
    );
`endif

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        incorrect_d = incorrect_q;
        streak_d    = streak_q;
        holdLoad    = 1'b0;
        holdClr     = 1'b0;
`ifdef STATUS_BLINK_EN
        blinkLoad   = 1'b0;
        blinkClr    = 1'b0;
`endif
        streakInc   = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);

        unique case (state_q)
            IDLE, SHOW: begin
                // A new result always wins over ack or the hold expiring.
                if (check_valid) begin
                    done_d      = 1'b1;
                    incorrect_d = ~check_ok;
                    streak_d    = check_ok ? '0 : streakInc;
                    if (!check_ok && streakInc == STREAK_W'(MAX_FAILS)) begin
                        state_d = LOCK;
                        holdClr = 1'b1;
`ifdef STATUS_BLINK_EN
                        blinkClr = 1'b1;
`endif
                    end else begin
                        state_d  = SHOW;
                        holdLoad = 1'b1;
`ifdef STATUS_BLINK_EN
                        blinkLoad = 1'b1;
`endif
                    end
                end else if (state_q == SHOW && (ack || holdExpire)) begin
                    state_d     = IDLE;
                    done_d      = 1'b0;
                    incorrect_d = 1'b0;
                    holdClr     = 1'b1;
`ifdef STATUS_BLINK_EN
                    blinkClr    = 1'b1;
                end else if (state_q == SHOW && incorrect_q && blinkExpire) begin
                    done_d    = ~done_q;
                    blinkLoad = 1'b1;
`endif
                end
            end
            LOCK: begin
                if (ack) begin
                    state_d     = IDLE;
                    done_d      = 1'b0;
                    incorrect_d = 1'b0;
                    streak_d    = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                done_d      = 1'b0;
                incorrect_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            incorrect_q <= 1'b0;
            locked_q    <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            incorrect_q <= incorrect_d;
            locked_q    <= (state_d == LOCK);
            streak_q    <= streak_d;
        end
    end

    assign done        = done_q;
    assign incorrect   = incorrect_q;
    assign locked      = locked_q;
    assign fail_streak = streak_q;

endmodule

// File: tb/tb_status_ctrl.sv
// Bench for status_ctrl: two instances (MAX_FAILS 3 and 15) against a timestamp-based reference model.
module tb_status_ctrl;

    localparam int HOLD  = 20;
    localparam int BLINK = 4;
`ifdef STATUS_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, checkValid, checkOk, ack;
    logic doneV [2];
    logic incorrectV [2];
    logic lockedV [2];
    logic [3:0] streakV [2];

    int checkCount = 0;
    int passCount  = 0;
    int cycleNo    = 0;

    // Model state: 0 = idle, 1 = showing a result, 2 = locked out.
    int mMode [2];
    int mStart [2];
    int mStreak [2];
    bit mOk [2];
    int maxFails [2] = '{3, 15};

    always #5 clk = ~clk;

    status_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .MAX_FAILS(3)) dutA (
        .clk(clk), .rst(rst), .check_valid(checkValid), .check_ok(checkOk), .ack(ack),
        .done(doneV[0]), .incorrect(incorrectV[0]), .locked(lockedV[0]), .fail_streak(streakV[0])
    );

    status_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .MAX_FAILS(15)) dutB (
        .clk(clk), .rst(rst), .check_valid(checkValid), .check_ok(checkOk), .ack(ack),
        .done(doneV[1]), .incorrect(incorrectV[1]), .locked(lockedV[1]), .fail_streak(streakV[1])
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNo, observed, expected);
        end
    endtask

    task automatic modelStep(input int k, input bit r, input bit cv, input bit ok, input bit ak);
        if (r) begin
            mMode[k]   = 0;
            mStreak[k] = 0;
        end else if (mMode[k] == 2) begin
            if (ak) begin
                mMode[k]   = 0;
                mStreak[k] = 0;
            end
        end else if (cv) begin
            if (ok) mStreak[k] = 0;
            else if (mStreak[k] < 15) mStreak[k] = mStreak[k] + 1;
            mOk[k]    = ok;
            mStart[k] = cycleNo;
            mMode[k]  = (!ok && mStreak[k] == maxFails[k]) ? 2 : 1;
        end else if (mMode[k] == 1 && (ak || cycleNo - mStart[k] >= HOLD)) begin
            mMode[k] = 0;
        end
    endtask

    task automatic compareInstance(input int k);
        string n;
        int expDone, expInc;
        n = (k == 0) ? "A" : "B";
        expDone = 0;
        expInc  = 0;
        if (mMode[k] == 2) begin
            expDone = 1;
            expInc  = 1;
        end else if (mMode[k] == 1) begin
            expInc  = mOk[k] ? 0 : 1;
            expDone = (mOk[k] || !BLINK_ON) ? 1 : ((((cycleNo - mStart[k]) / BLINK) % 2 == 0) ? 1 : 0);
        end
        checkOutput({n, ".done"}, int'(doneV[k]), expDone);
        checkOutput({n, ".incorrect"}, int'(incorrectV[k]), expInc);
        checkOutput({n, ".locked"}, int'(lockedV[k]), (mMode[k] == 2) ? 1 : 0);
        checkOutput({n, ".fail_streak"}, int'(streakV[k]), mStreak[k]);
    endtask

    task automatic applyStimulus(input bit r, input bit cv, input bit ok, input bit ak);
        rst        = r;
        checkValid = cv;
        checkOk    = ok;
        ack        = ak;
        @(posedge clk);
        cycleNo++;
        for (int k = 0; k < 2; k++) modelStep(k, r, cv, ok, ak);
        #1;
        for (int k = 0; k < 2; k++) compareInstance(k);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mMode[k] = 0; mStart[k] = 0; mStreak[k] = 0; mOk[k] = 1'b0;
        end
        rst = 1'b1; checkValid = 1'b0; checkOk = 1'b0; ack = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        // Correct result held for the full window, then timeout.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        idleCycles(24);

        // Incorrect result (blink window when enabled).
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(24);

        // Three failures 30 cycles apart lock instance A; a correct result is then ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            idleCycles(29);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(2);

        // Failure then correct result together with ack: the new result wins.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        idleCycles(22);

        // Reset in the middle of a display.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        idleCycles(2);

        // Twenty back-to-back failures: B saturates and locks at 15.
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("B.satStreak", int'(streakV[1]), 15);
        checkOutput("B.satLocked", int'(lockedV[1]), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(2);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 24) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/status_ctrl.md
STATUS_CTRL -- requirements
Module: status_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, result display time in clk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 12_500_000, half-period of the failure blink in clk cycles.
REQ-003 SHALL have parameter MAX_FAILS, default 3, consecutive failures that force lockout (range 1..15).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port check_valid, input, 1, one-cycle pulse: a check result is presented.
REQ-007 SHALL have port check_ok, input, 1, result qualifier, sampled only when check_valid=1 (1=correct).
REQ-008 SHALL have port ack, input, 1, one-cycle clear pulse (debounced button, synchronised upstream).
REQ-009 SHALL have port done, output, 1, registered drive of the status display "done" input.
REQ-010 SHALL have port incorrect, output, 1, registered drive of the status display "incorrect" input.
REQ-011 SHALL have port locked, output, 1, high while in lockout.
REQ-012 SHALL have port fail_streak, output, 4, consecutive-failure count, saturating.

Function
REQ-013 SHALL implement FSM states IDLE, SHOW and LOCK.
REQ-014 IDLE: done=0, incorrect=0, locked=0.
REQ-015 IDLE with check_valid at edge t: latch check_ok, load hold timer with HOLD_CYCLES, enter SHOW; done=1 and incorrect=~check_ok visible from cycle t+1.
REQ-016 Correct result: fail_streak cleared to 0.
REQ-017 Incorrect result: fail_streak incremented, saturating at 15.
REQ-018 Incorrect result that brings fail_streak to MAX_FAILS: enter LOCK instead of SHOW.
REQ-019 SHOW, no interruption: done high for exactly HOLD_CYCLES cycles, then return to IDLE with done=0 and incorrect=0 in the same cycle.
REQ-020 SHOW with ack: next cycle IDLE.
REQ-021 SHOW with check_valid: restart SHOW with the new result and a reloaded timer (latest result wins).
REQ-022 SHOW with ack and check_valid in the same cycle: check_valid wins.
REQ-023 LOCK: done=1, incorrect=1, locked=1, no timeout; check_valid is ignored and fail_streak is frozen.
REQ-024 LOCK with ack: next cycle IDLE with fail_streak=0.
REQ-025 check_ok SHALL be ignored when check_valid=0.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, done=0, incorrect=0, locked=0, fail_streak=0, timers cleared, from any state.
REQ-028 rst SHALL take priority over check_valid and ack in the same cycle.
REQ-029 rst asserted mid-SHOW or mid-LOCK SHALL abort the operation with no residual blink or hold.

Configuration
REQ-030 Macro STATUS_BLINK_EN defined: in SHOW with incorrect=1, done SHALL start high and toggle every BLINK_CYCLES cycles; incorrect stays high; on exit done=0.
REQ-031 Blink SHALL NOT apply to correct results or to LOCK, where done is solid.
REQ-032 Macro STATUS_BLINK_EN undefined: done SHALL be solid in SHOW and the blink counter SHALL be absent from the netlist.

Structure
REQ-033 Package status_pkg SHALL hold the state enum (IDLE, SHOW, LOCK), the fail_streak width (4) and its saturation value (15).
REQ-034 Sub-module status_timer SHALL provide a loadable down-counter with a one-cycle expire pulse, width $clog2(HOLD_CYCLES+1).
REQ-035 status_timer SHALL be instantiated once for hold and once for blink (blink instance only under STATUS_BLINK_EN).
REQ-036 status_ctrl SHALL NOT instantiate the display decoder; it is connected at top level.

Verification (HOLD_CYCLES=20, BLINK_CYCLES=4, MAX_FAILS=3)
REQ-037 check_valid=1, check_ok=1 at cycle 5 -> done=1, incorrect=0 cycles 6..25; cycle 26 done=0; fail_streak=0.
REQ-038 check_ok=0 at cycle 5 with STATUS_BLINK_EN -> incorrect=1 cycles 6..25; done 1,1,1,1,0,0,0,0,... over that window; fail_streak=1.
REQ-039 Three check_ok=0 pulses 30 cycles apart -> after the third: locked=1, done=1, incorrect=1; then check_ok=1 ignored; ack -> next cycle IDLE, fail_streak=0.
REQ-040 check_ok=0 at cycle 5, then check_ok=1 plus ack at cycle 10 -> SHOW correct, done high cycles 11..30, fail_streak=0.
REQ-041 rst at cycle 12 during SHOW -> cycle 13: all outputs 0, state IDLE.
REQ-042 check_ok=0 pulse, then check_ok=1 pulse -> fail_streak 1 then 0; 20 consecutive failures with MAX_FAILS=15 -> saturation at 15 checked.
